// File: rtl/param_enc_pkg.sv
// Shared helpers for the one-hot-to-binary priority encoder: index search,
// multi-hot detection and the output-register fill state.
package param_enc_pkg;

  // Widest input bus the helper functions accept.
  localparam int MAX_WIDTH = 256;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fill_e;

  function automatic int lowest_set_index(input logic [MAX_WIDTH-1:0] vector, input int width);
    int idx;
    idx = 0;
    // Scan downwards so the last hit written is the lowest set bit.
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      if ((i < width) && vector[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic is_multi_hot(input logic [MAX_WIDTH-1:0] vector);
    return |(vector & (vector - MAX_WIDTH'(1)));
  endfunction

endpackage

// File: rtl/param_enc_core.sv
// Combinational one-hot-to-binary priority encoder with zero and multi-hot flags.
module param_enc_core
  import param_enc_pkg::*;
#(
  parameter int input_width  = 4,
  parameter int output_width = 2
) (
  input  logic [input_width-1:0]  x,
  output logic [output_width-1:0] idx,
  output logic                    zero,
  output logic                    multi
);

  logic [MAX_WIDTH-1:0] x_ext;

  always_comb begin
    x_ext                    = '0;
    x_ext[input_width-1:0]   = x;
    idx                      = output_width'(lowest_set_index(x_ext, input_width));
    zero                     = (x == '0);
    multi                    = is_multi_hot(x_ext);
  end

endmodule

// File: rtl/param_enc.sv
// Registered priority encoder: valid/ready on both sides, one-entry output
// register and a saturating count of accepted multi-hot words.
module param_enc
  import param_enc_pkg::*;
#(
  parameter int input_width   = 4,
  parameter int output_width  = 2,
  parameter int err_cnt_width = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [input_width-1:0]   x,
  input  logic                     x_valid,
  output logic                     x_ready,
  output logic [output_width-1:0]  y,
  output logic                     y_zero,
  output logic                     y_multi,
  output logic                     y_valid,
  input  logic                     y_ready,
  input  logic                     err_clr,
  output logic [err_cnt_width-1:0] err_cnt
);

  localparam logic [err_cnt_width-1:0] ERR_CNT_MAX = '1;

  generate
    if ((2 ** output_width) < input_width) begin : g_bad_output_width
      $fatal(1, "param_enc: output_width too small to index input_width bits");
    end
    if (input_width > MAX_WIDTH) begin : g_bad_input_width
      $fatal(1, "param_enc: input_width exceeds helper function range");
    end
  endgenerate

  fill_e                    state_reg;
  logic [output_width-1:0]  y_reg;
  logic                     zero_reg;
  logic                     multi_reg;
  logic [err_cnt_width-1:0] err_cnt_reg;

  logic [output_width-1:0]  core_idx;
  logic                     core_zero;
  logic                     core_multi;
  logic                     accept;
  logic                     drain;

  param_enc_core #(
    .input_width (input_width),
    .output_width(output_width)
  ) u_core (
    .x    (x),
    .idx  (core_idx),
    .zero (core_zero),
    .multi(core_multi)
  );

  assign y_valid = (state_reg == FULL);
  assign x_ready = !y_valid || y_ready;
  assign accept  = x_valid && x_ready;
  assign drain   = y_valid && y_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      y_reg     <= '0;
      zero_reg  <= 1'b0;
      multi_reg <= 1'b0;
    end else if (accept) begin
      state_reg <= FULL;
      y_reg     <= core_idx;
      zero_reg  <= core_zero;
      multi_reg <= core_multi;
    end else if (drain) begin
      state_reg <= EMPTY;
    end
  end

  // Clear takes priority; an increment in the same cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      err_cnt_reg <= '0;
    end else if (accept && core_multi && (err_cnt_reg != ERR_CNT_MAX)) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign y       = y_reg;
  assign y_zero  = zero_reg;
  assign y_multi = multi_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_param_enc.sv
// Bench for param_enc: directed test-plan cases then random traffic, two
// instances (8-bit and 2-bit error counters) driven in lockstep.
module tb_param_enc;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic       x_valid;
  logic       y_ready;
  logic       err_clr;

  logic       x_ready_a, y_zero_a, y_multi_a, y_valid_a;
  logic [1:0] y_a;
  logic [7:0] err_cnt_a;
  logic       x_ready_b, y_zero_b, y_multi_b, y_valid_b;
  logic [1:0] y_b;
  logic [1:0] err_cnt_b;

  int checks = 0;
  int errors = 0;

  // reference state
  bit m_valid;
  int m_y;
  bit m_zero;
  bit m_multi;
  int m_cnt_a;
  int m_cnt_b;

  param_enc #(.input_width(4), .output_width(2), .err_cnt_width(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(x_ready_a),
    .y(y_a), .y_zero(y_zero_a), .y_multi(y_multi_a), .y_valid(y_valid_a),
    .y_ready(y_ready), .err_clr(err_clr), .err_cnt(err_cnt_a)
  );

  param_enc #(.input_width(4), .output_width(2), .err_cnt_width(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .x(x), .x_valid(x_valid), .x_ready(x_ready_b),
    .y(y_b), .y_zero(y_zero_b), .y_multi(y_multi_b), .y_valid(y_valid_b),
    .y_ready(y_ready), .err_clr(err_clr), .err_cnt(err_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_one(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_y = 0; m_zero = 0; m_multi = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic check_outputs();
    check("y_valid_a", int'(y_valid_a), int'(m_valid));
    check("y_valid_b", int'(y_valid_b), int'(m_valid));
    check("err_cnt_a", int'(err_cnt_a), m_cnt_a);
    check("err_cnt_b", int'(err_cnt_b), m_cnt_b);
    if (m_valid) begin
      check("y_a", int'(y_a), m_y);
      check("y_zero_a", int'(y_zero_a), int'(m_zero));
      check("y_multi_a", int'(y_multi_a), int'(m_multi));
      check("y_b", int'(y_b), m_y);
      check("y_multi_b", int'(y_multi_b), int'(m_multi));
    end
  endtask

  // One clock cycle of stimulus; checks x_ready before the edge and outputs after.
  task automatic cycle(input logic [3:0] xv, input bit xval, input bit yr, input bit clr);
    bit acc;
    bit multi;
    x = xv; x_valid = xval; y_ready = yr; err_clr = clr;
    #1;
    check("x_ready_a", int'(x_ready_a), int'(!m_valid || yr));
    check("x_ready_b", int'(x_ready_b), int'(!m_valid || yr));
    @(posedge clk);
    acc   = xval && (!m_valid || yr);
    multi = ($countones(xv) > 1);
    if (acc) begin
      m_valid = 1; m_y = lowest_one(xv); m_zero = (xv == 0); m_multi = multi;
    end else if (m_valid && yr) begin
      m_valid = 0;
    end
    if (clr) begin
      m_cnt_a = 0; m_cnt_b = 0;
    end else if (acc && multi) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    #1;
    check_outputs();
    $display("cycle x=%b xv=%0d yr=%0d clr=%0d -> y=%0d vld=%0d zero=%0d multi=%0d cnt=%0d/%0d",
             xv, xval, yr, clr, y_a, y_valid_a, y_zero_a, y_multi_a, err_cnt_a, err_cnt_b);
  endtask

  initial begin
    logic [3:0] rx;
    rst_n = 1'b0; x = '0; x_valid = 1'b0; y_ready = 1'b0; err_clr = 1'b0;
    model_reset();
    #3;
    check("rst_y_valid", int'(y_valid_a), 0);
    check("rst_y", int'(y_a), 0);
    check("rst_y_zero", int'(y_zero_a), 0);
    check("rst_y_multi", int'(y_multi_a), 0);
    check("rst_err_cnt", int'(err_cnt_a), 0);
    check("rst_x_ready", int'(x_ready_a), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cycle(4'b0100, 1, 1, 0);                   // y=2
    cycle(4'b0110, 1, 1, 0);                   // y=1, multi, cnt=1
    cycle(4'b0101, 1, 1, 1);                   // multi accept, clear wins
    cycle(4'b0000, 1, 1, 0);                   // zero word
    for (int k = 0; k < 4; k++) cycle(4'(1 << k), 1, 1, 0);  // decoder round trip
    cycle(4'b1000, 1, 1, 0);                   // y=3
    for (int i = 0; i < 5; i++) cycle(4'b0001, 1, 0, 0);     // backpressure
    cycle(4'b0001, 1, 1, 0);                   // released, y=0
    for (int i = 0; i < 5; i++) cycle(4'b1111, 1, 1, 0);     // saturate small counter
    cycle(4'b1100, 1, 0, 0);
    cycle(4'b0000, 0, 0, 0);                   // full and stalled

    // Asynchronous reset in mid-cycle, no clock edge before checking.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_y_valid_a", int'(y_valid_a), 0);
    check("arst_y_a", int'(y_a), 0);
    check("arst_err_cnt_a", int'(err_cnt_a), 0);
    check("arst_y_valid_b", int'(y_valid_b), 0);
    check("arst_err_cnt_b", int'(err_cnt_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rx = 4'($urandom);
      else rx = 4'(1 << $urandom_range(0, 3));
      cycle(rx, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
